// File: rtl/midi_uart_pkg.sv
// Shared types and constants for the MIDI serial receiver.
package midi_uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4,
    BREAK = 3'd5
  } rx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  localparam logic [4:0] RT_PREFIX = 5'h1F;

  // Expected parity bit for a zero-extended data word.
  function automatic logic parity_of(input logic [8:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/midi_rx_sampler.sv
// Line conditioning: synchroniser, start-edge detect, bit phase counter and
// 3-sample majority vote around the bit centre.
module midi_rx_sampler #(
  parameter int OVERSAMPLE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_in,
  input  logic hunt,
  output logic start_edge,
  output logic bit_tick,
  output logic bit_val,
  output logic rx_s
);
  import midi_uart_pkg::*;

  localparam int PW = $clog2(OVERSAMPLE);
  localparam int C  = OVERSAMPLE / 2;

  logic          sync1_q, rx_s_q, rx_d_q;
  logic [PW-1:0] phase_q, phase_d;
  logic          samp_a_q, samp_a_d;
  logic          samp_b_q, samp_b_d;

  assign start_edge = rx_d_q & ~rx_s_q;
  assign bit_tick   = (phase_q == PW'(C + 1));
  assign bit_val    = (samp_a_q & samp_b_q) | (samp_a_q & rx_s_q) | (samp_b_q & rx_s_q);
  assign rx_s       = rx_s_q;

  always_comb begin
    phase_d  = phase_q;
    samp_a_d = samp_a_q;
    samp_b_d = samp_b_q;
    // Only a start edge seen while hunting realigns the bit phase.
    if (hunt && start_edge) begin
      phase_d = '0;
    end else if (phase_q == PW'(OVERSAMPLE - 1)) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + PW'(1);
    end
    if (phase_q == PW'(C - 1)) begin
      samp_a_d = rx_s_q;
    end else begin
      samp_a_d = samp_a_q;
    end
    if (phase_q == PW'(C)) begin
      samp_b_d = rx_s_q;
    end else begin
      samp_b_d = samp_b_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      rx_s_q   <= 1'b1;
      rx_d_q   <= 1'b0;
      phase_q  <= '0;
      samp_a_q <= 1'b0;
      samp_b_q <= 1'b0;
    end else begin
      sync1_q  <= rx_in;
      rx_s_q   <= sync1_q;
      rx_d_q   <= rx_s_q;
      phase_q  <= phase_d;
      samp_a_q <= samp_a_d;
      samp_b_q <= samp_b_d;
    end
  end

endmodule

// File: rtl/midi_uart_rx_param.sv
// Parametrised MIDI receiver: frame FSM, error detection, FIFO routing and a
// saturating error counter on top of the line sampler.
module midi_uart_rx_param #(
  parameter int OVERSAMPLE = 8,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int RT_SPLIT   = 1,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 midi_system_clock,
  input  logic                 midi_rst,
  input  logic                 midi_uart_in,
  input  logic                 data_fifo_full,
  input  logic                 real_fifo_full,
  input  logic                 err_clear,
  output logic [DATA_BITS-1:0] fifo_data,
  output logic                 data_fifo_wr,
  output logic                 real_fifo_wr,
  output logic                 err_parity,
  output logic                 err_framing,
  output logic                 err_overrun,
  output logic                 line_break,
  output logic [ERR_CNT_W-1:0] err_count
);
  import midi_uart_pkg::*;

  localparam int         PW       = $clog2(OVERSAMPLE);
  localparam bit         RT_EN    = (RT_SPLIT != 0) && (DATA_BITS == 8);
  localparam logic       PAR_ODD  = (PARITY == PARITY_ODD);
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  rx_state_e             state_q, state_d;
  logic [3:0]            bit_idx_q, bit_idx_d;
  logic                  stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  par_bad_q, par_bad_d;
  logic                  stop_bad_q, stop_bad_d;
  logic [PW-1:0]         hi_cnt_q, hi_cnt_d;
  logic [DATA_BITS-1:0]  fifo_data_q, fifo_data_d;
  logic                  pend_q, pend_d;
  logic                  pend_rt_q, pend_rt_d;
  logic                  err_par_q, err_par_d;
  logic                  err_frm_q, err_frm_d;
  logic                  line_break_q, line_break_d;
  logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;

  logic       start_edge_s, bit_tick_s, bit_val_s, rx_s, hunt_s;
  logic [8:0] data_ext_s;
  logic       is_rt_s, stop_bad_s, err_any_s;

  midi_rx_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
    .clk        (midi_system_clock),
    .rst        (midi_rst),
    .rx_in      (midi_uart_in),
    .hunt       (hunt_s),
    .start_edge (start_edge_s),
    .bit_tick   (bit_tick_s),
    .bit_val    (bit_val_s),
    .rx_s       (rx_s)
  );

  assign hunt_s     = (state_q == IDLE);
  assign data_ext_s = 9'(shift_q);
  assign is_rt_s    = RT_EN && (data_ext_s[7:3] == RT_PREFIX);
  assign stop_bad_s = stop_bad_q | ~bit_val_s;

  always_comb begin
    state_d      = state_q;
    bit_idx_d    = bit_idx_q;
    stop_idx_d   = stop_idx_q;
    shift_d      = shift_q;
    par_bad_d    = par_bad_q;
    stop_bad_d   = stop_bad_q;
    hi_cnt_d     = hi_cnt_q;
    fifo_data_d  = fifo_data_q;
    pend_d       = 1'b0;
    pend_rt_d    = pend_rt_q;
    err_par_d    = 1'b0;
    err_frm_d    = 1'b0;
    line_break_d = line_break_q;
    case (state_q)
      IDLE: begin
        bit_idx_d  = 4'd0;
        stop_idx_d = 1'b0;
        par_bad_d  = 1'b0;
        stop_bad_d = 1'b0;
        if (start_edge_s) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (bit_tick_s) begin
          state_d   = bit_val_s ? IDLE : DATA;
          bit_idx_d = 4'd0;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (bit_tick_s) begin
          // LSB arrives first, so after DATA_BITS shifts it sits at bit 0.
          shift_d = {bit_val_s, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == LAST_BIT) begin
            state_d = (PARITY != PARITY_NONE) ? PAR : STOP;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end else begin
          state_d = DATA;
        end
      end
      PAR: begin
        if (bit_tick_s) begin
          par_bad_d = bit_val_s ^ parity_of(data_ext_s, PAR_ODD);
          state_d   = STOP;
        end else begin
          state_d = PAR;
        end
      end
      STOP: begin
        if (bit_tick_s && (stop_idx_q == 1'(STOP_BITS - 1))) begin
          state_d = IDLE;
          if (stop_bad_s && (shift_q == '0) && !par_bad_q) begin
            line_break_d = 1'b1;
            err_frm_d    = 1'b1;
            hi_cnt_d     = '0;
            state_d      = BREAK;
          end else if (stop_bad_s) begin
            err_frm_d = 1'b1;
          end else if (par_bad_q) begin
            err_par_d = 1'b1;
          end else begin
            fifo_data_d = shift_q;
            pend_d      = 1'b1;
            pend_rt_d   = is_rt_s;
          end
        end else if (bit_tick_s) begin
          stop_idx_d = 1'b1;
          stop_bad_d = stop_bad_s;
        end else begin
          state_d = STOP;
        end
      end
      BREAK: begin
        if (!rx_s) begin
          hi_cnt_d = '0;
        end else if (hi_cnt_q == PW'(OVERSAMPLE - 1)) begin
          hi_cnt_d     = '0;
          line_break_d = 1'b0;
          state_d      = IDLE;
        end else begin
          hi_cnt_d = hi_cnt_q + PW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The full flag is judged in the strobe cycle itself, one cycle after the decision.
  assign data_fifo_wr = pend_q & ~pend_rt_q & ~data_fifo_full;
  assign real_fifo_wr = pend_q &  pend_rt_q & ~real_fifo_full;
  assign err_overrun  = pend_q & (pend_rt_q ? real_fifo_full : data_fifo_full);
  assign err_any_s    = err_par_q | err_frm_q | err_overrun;

  always_comb begin
    err_count_d = err_count_q;
    if (err_clear) begin
      err_count_d = '0;
    end else if (err_any_s && (err_count_q != {ERR_CNT_W{1'b1}})) begin
      err_count_d = err_count_q + ERR_CNT_W'(1);
    end else begin
      err_count_d = err_count_q;
    end
  end

  always_ff @(posedge midi_system_clock or posedge midi_rst) begin
    if (midi_rst) begin
      state_q      <= IDLE;
      bit_idx_q    <= 4'd0;
      stop_idx_q   <= 1'b0;
      shift_q      <= '0;
      par_bad_q    <= 1'b0;
      stop_bad_q   <= 1'b0;
      hi_cnt_q     <= '0;
      fifo_data_q  <= '0;
      pend_q       <= 1'b0;
      pend_rt_q    <= 1'b0;
      err_par_q    <= 1'b0;
      err_frm_q    <= 1'b0;
      line_break_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      bit_idx_q    <= bit_idx_d;
      stop_idx_q   <= stop_idx_d;
      shift_q      <= shift_d;
      par_bad_q    <= par_bad_d;
      stop_bad_q   <= stop_bad_d;
      hi_cnt_q     <= hi_cnt_d;
      fifo_data_q  <= fifo_data_d;
      pend_q       <= pend_d;
      pend_rt_q    <= pend_rt_d;
      err_par_q    <= err_par_d;
      err_frm_q    <= err_frm_d;
      line_break_q <= line_break_d;
      err_count_q  <= err_count_d;
    end
  end

  assign fifo_data   = fifo_data_q;
  assign err_parity  = err_par_q;
  assign err_framing = err_frm_q;
  assign line_break  = line_break_q;
  assign err_count   = err_count_q;

endmodule
